rrf_retire_queue: RTL and testbench
===================================

# rrf_retire_queue

In-order retire queue for renamed destinations. Dispatch allocates a rename tag per destination-writing instruction in program order. Execution units return results by tag, in any order. The queue releases entries strictly in allocation order, producing one registered architectural write per cycle toward the architectural register file. It is the consumer/release end of the renaming register file protocol.

## Interface
Parameters:
- DEPTH, 16, number of rename entries (power of two)
- TAG_W, 4, tag width, log2(DEPTH)
- ARCH_W, 5, architectural register index width
- DATA_W, 32, data width

Ports:
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- ALLOC_VALID  in  1  dispatch requests a tag
- ALLOC_ARCH_REG  in  ARCH_W  destination architectural register
- ALLOC_READY  out  1  combinational, COUNT < DEPTH
- ALLOC_TAG  out  TAG_W  combinational, equals tail pointer; tag granted on accepted alloc
- WB_VALID  in  1  execution writeback
- WB_TAG  in  TAG_W  writeback tag
- WB_DATA  in  DATA_W  writeback value
- WB_ERR  out  1  registered one-cycle pulse, illegal writeback
- RETIRE_VALID  out  1  registered, architectural write this cycle
- RETIRE_ARCH_REG  out  ARCH_W  registered
- RETIRE_DATA  out  DATA_W  registered
- RETIRE_TAG  out  TAG_W  registered, tag released
- FLUSH  in  1  discard all in-flight entries
- COUNT  out  TAG_W+1  occupied entries
- EMPTY  out  1  COUNT == 0

## Operation
- Per-entry state: valid, done, arch_reg, data. Global state: head, tail, count.
- Alloc accepted when ALLOC_VALID && ALLOC_READY.
  - Sets entry[tail] to valid=1, done=0, arch_reg=ALLOC_ARCH_REG.
  - tail increments modulo DEPTH.
- Alloc while not ready is ignored; no state change.
- Writeback legal when entry[WB_TAG] is valid && !done.
  - Sets done=1 and data=WB_DATA.
- Writeback to an invalid entry, or to an entry already done, is ignored. WB_ERR pulses on the next cycle.
- Retire evaluates registered state only. When entry[head] is valid && done:
  - RETIRE_* outputs load entry contents; RETIRE_VALID=1.
  - Entry is cleared; head increments modulo DEPTH.
- Otherwise RETIRE_VALID=0 and the other RETIRE_* outputs hold their previous values.
- count updates as +alloc −retire; simultaneous alloc and retire leaves count unchanged.
- ALLOC_READY does not credit a same-cycle retire. When full, alloc waits one cycle after the retire.
- FLUSH has highest priority:
  - All valid/done bits clear; head=tail=count=0.
  - Same-cycle alloc, writeback and retire are suppressed; RETIRE_VALID=0 and WB_ERR=0 next cycle.
- RESET behaves as FLUSH. In addition, RETIRE_ARCH_REG, RETIRE_DATA and RETIRE_TAG reset to 0.
- Reset values: RETIRE_VALID=0, WB_ERR=0, COUNT=0, EMPTY=1, ALLOC_READY=1, ALLOC_TAG=0.

## Timing
- Alloc at edge k: entry valid from cycle k+1. A writeback to that tag in cycle k is illegal (WB_ERR).
- Writeback at edge k to the head entry: retire decided in cycle k+1, RETIRE_VALID high after edge k+1. Latency is 2 edges; there is no writeback-to-retire bypass.
- Throughput: one alloc, one writeback and one retire per cycle, concurrently.
- Writeback and retire never target the same entry in one cycle; the retire path requires done already set.
- Pointer wrap: tag DEPTH−1 is followed by tag 0. The full/empty distinction comes from count, not pointer comparison.

## Structure
- Shared package rrf_pkg holds:
  - DEPTH, TAG_W, ARCH_W and DATA_W constants
  - the rrf_entry_t struct {valid, done, arch_reg, data}, shared with the renaming register file and dispatch.
- One natural sub-module: rrf_ptr_ctr, a modulo-DEPTH pointer with increment enable and synchronous clear, instantiated for head and tail.
- Entry array, count and output registers live in the top module.

## Test plan
- Reset, then alloc arch 5, 6, 7 on consecutive cycles -> ALLOC_TAG 0, 1, 2; COUNT=3; EMPTY=0; RETIRE_VALID stays 0.
- Writebacks in order tag2=0xAA, tag1=0xBB, tag0=0xCC -> retires in order (tag0, arch5, 0xCC), (1, 6, 0xBB), (2, 7, 0xAA) on three consecutive cycles, the first two edges after the tag0 writeback.
- Alloc 16 entries -> ALLOC_READY=0. A 17th ALLOC_VALID is ignored and COUNT stays 16. Writeback and retire tag0 -> ALLOC_READY=1 the cycle after retire; next ALLOC_TAG=0.
- Run 20 alloc/writeback/retire sequences -> tags wrap 15 to 0; retire order matches alloc order; COUNT returns to 0.
- Writeback to an unallocated tag 9, and a second writeback to already-done tag 0 -> WB_ERR single-cycle pulse each time; data unchanged; no extra retire.
- 5 entries in flight, FLUSH asserted together with ALLOC_VALID and WB_VALID -> next cycle COUNT=0, EMPTY=1, ALLOC_TAG=0, RETIRE_VALID=0, WB_ERR=0.

Source files
------------

// File: rtl/rrf_pkg.sv
// Shared renaming-register-file definitions: queue geometry and the per-entry record
// used by dispatch, the rename file and the retire queue.
package rrf_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int ARCH_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [ARCH_W-1:0] arch_reg;
    logic [DATA_W-1:0] data;
  } rrf_entry_t;

endpackage

// File: rtl/rrf_ptr_ctr.sv
// Modulo-2^TAG_W ring pointer with increment enable and synchronous clear.
module rrf_ptr_ctr #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [TAG_W-1:0] ptr_o
);

  logic [TAG_W-1:0] ptr_q, ptr_d;

  // Natural binary overflow gives the DEPTH-1 -> 0 wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rrf_retire_queue.sv
// In-order retire queue: allocates rename tags in program order, collects
// out-of-order writebacks, and releases one architectural write per cycle.
module rrf_retire_queue
  import rrf_pkg::*;
#(
  parameter int DEPTH  = rrf_pkg::DEPTH,
  parameter int TAG_W  = rrf_pkg::TAG_W,
  parameter int ARCH_W = rrf_pkg::ARCH_W,
  parameter int DATA_W = rrf_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALLOC_VALID,
  input  logic [ARCH_W-1:0] ALLOC_ARCH_REG,
  output logic              ALLOC_READY,
  output logic [TAG_W-1:0]  ALLOC_TAG,
  input  logic              WB_VALID,
  input  logic [TAG_W-1:0]  WB_TAG,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              WB_ERR,
  output logic              RETIRE_VALID,
  output logic [ARCH_W-1:0] RETIRE_ARCH_REG,
  output logic [DATA_W-1:0] RETIRE_DATA,
  output logic [TAG_W-1:0]  RETIRE_TAG,
  input  logic              FLUSH,
  output logic [TAG_W:0]    COUNT,
  output logic              EMPTY
);

  localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

  rrf_entry_t        ent_q [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count_q, count_d;

  logic              ret_valid_q;
  logic [ARCH_W-1:0] ret_arch_q;
  logic [DATA_W-1:0] ret_data_q;
  logic [TAG_W-1:0]  ret_tag_q;
  logic              wb_err_q;

  logic              flush_w;
  logic              alloc_do;
  logic              wb_legal;
  logic              wb_do;
  logic              wb_err_d;
  logic              retire_do;
  rrf_entry_t        head_ent;
  rrf_entry_t        wb_ent;

  // Reset is a flush plus clearing of the retire output registers.
  assign flush_w  = RESET | FLUSH;

  assign head_ent = ent_q[head];
  assign wb_ent   = ent_q[WB_TAG];

  // Readiness looks only at registered count: a same-cycle retire is not credited.
  assign ALLOC_READY = (count_q < FULL_CNT);
  assign ALLOC_TAG   = tail;

  assign alloc_do  = ALLOC_VALID && ALLOC_READY && !flush_w;
  assign wb_legal  = WB_VALID && wb_ent.valid && !wb_ent.done;
  assign wb_do     = wb_legal && !flush_w;
  assign wb_err_d  = WB_VALID && !wb_legal && !flush_w;
  assign retire_do = head_ent.valid && head_ent.done && !flush_w;

  always_comb begin
    count_d = count_q;
    if (flush_w)
      count_d = '0;
    else if (alloc_do && !retire_do)
      count_d = count_q + 1'b1;
    else if (!alloc_do && retire_do)
      count_d = count_q - 1'b1;
  end

  rrf_ptr_ctr #(.TAG_W(TAG_W)) u_head (
    .clk_i (CLK),
    .clr_i (flush_w),
    .inc_i (retire_do),
    .ptr_o (head)
  );

  rrf_ptr_ctr #(.TAG_W(TAG_W)) u_tail (
    .clk_i (CLK),
    .clr_i (flush_w),
    .inc_i (alloc_do),
    .ptr_o (tail)
  );

  // Alloc, writeback and retire never hit the same entry in one cycle:
  // alloc targets an invalid slot, writeback needs !done, retire needs done.
  always_ff @(posedge CLK) begin
    if (flush_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
    end else begin
      if (alloc_do) begin
        ent_q[tail].valid    <= 1'b1;
        ent_q[tail].done     <= 1'b0;
        ent_q[tail].arch_reg <= ALLOC_ARCH_REG;
      end
      if (wb_do) begin
        ent_q[WB_TAG].done <= 1'b1;
        ent_q[WB_TAG].data <= WB_DATA;
      end
      if (retire_do) begin
        ent_q[head].valid <= 1'b0;
        ent_q[head].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ret_valid_q <= 1'b0;
      wb_err_q    <= 1'b0;
      ret_arch_q  <= '0;
      ret_data_q  <= '0;
      ret_tag_q   <= '0;
    end else begin
      ret_valid_q <= retire_do;
      wb_err_q    <= wb_err_d;
      if (retire_do) begin
        ret_arch_q <= head_ent.arch_reg;
        ret_data_q <= head_ent.data;
        ret_tag_q  <= head;
      end
    end
  end

  assign RETIRE_VALID    = ret_valid_q;
  assign RETIRE_ARCH_REG = ret_arch_q;
  assign RETIRE_DATA     = ret_data_q;
  assign RETIRE_TAG      = ret_tag_q;
  assign WB_ERR          = wb_err_q;
  assign COUNT           = count_q;
  assign EMPTY           = (count_q == '0);

endmodule

// File: tb/tb_rrf_retire_queue.sv
// Directed bench for rrf_retire_queue: ordering, full/wrap, illegal writeback and flush.
module tb_rrf_retire_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ALLOC_VALID = 1'b0;
  logic [4:0]  ALLOC_ARCH_REG = '0;
  logic        ALLOC_READY;
  logic [3:0]  ALLOC_TAG;
  logic        WB_VALID = 1'b0;
  logic [3:0]  WB_TAG = '0;
  logic [31:0] WB_DATA = '0;
  logic        WB_ERR;
  logic        RETIRE_VALID;
  logic [4:0]  RETIRE_ARCH_REG;
  logic [31:0] RETIRE_DATA;
  logic [3:0]  RETIRE_TAG;
  logic        FLUSH = 1'b0;
  logic [4:0]  COUNT;
  logic        EMPTY;

  int passed = 0;
  int total  = 0;

  rrf_retire_queue dut (
    .CLK(CLK), .RESET(RESET),
    .ALLOC_VALID(ALLOC_VALID), .ALLOC_ARCH_REG(ALLOC_ARCH_REG),
    .ALLOC_READY(ALLOC_READY), .ALLOC_TAG(ALLOC_TAG),
    .WB_VALID(WB_VALID), .WB_TAG(WB_TAG), .WB_DATA(WB_DATA), .WB_ERR(WB_ERR),
    .RETIRE_VALID(RETIRE_VALID), .RETIRE_ARCH_REG(RETIRE_ARCH_REG),
    .RETIRE_DATA(RETIRE_DATA), .RETIRE_TAG(RETIRE_TAG),
    .FLUSH(FLUSH), .COUNT(COUNT), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; ALLOC_VALID = 1'b0; WB_VALID = 1'b0; FLUSH = 1'b0;
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (RETIRE_VALID !== 1'b0) $display("FAIL rst_rv got %0h want 0", RETIRE_VALID); else passed++;
    total++; if (WB_ERR !== 1'b0) $display("FAIL rst_wberr got %0h want 0", WB_ERR); else passed++;
    total++; if (COUNT !== 5'd0) $display("FAIL rst_count got %0d want 0", COUNT); else passed++;
    total++; if (EMPTY !== 1'b1) $display("FAIL rst_empty got %0h want 1", EMPTY); else passed++;
    total++; if (ALLOC_READY !== 1'b1) $display("FAIL rst_ready got %0h want 1", ALLOC_READY); else passed++;
    total++; if (ALLOC_TAG !== 4'd0) $display("FAIL rst_tag got %0d want 0", ALLOC_TAG); else passed++;
    total++; if ({RETIRE_ARCH_REG, RETIRE_DATA, RETIRE_TAG} !== 41'd0)
      $display("FAIL rst_retire_regs got %0h/%0h/%0h want 0/0/0", RETIRE_ARCH_REG, RETIRE_DATA, RETIRE_TAG);
    else passed++;
  endtask

  task automatic test_alloc();
    for (int k = 5; k <= 7; k++) begin
      total++; if (ALLOC_TAG !== 4'(k - 5)) $display("FAIL alloc_tag%0d got %0d want %0d", k, ALLOC_TAG, k - 5); else passed++;
      ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'(k);
      tick();
      total++; if (RETIRE_VALID !== 1'b0) $display("FAIL alloc_rv%0d got %0h want 0", k, RETIRE_VALID); else passed++;
    end
    ALLOC_VALID = 1'b0;
    total++; if (COUNT !== 5'd3) $display("FAIL alloc_count got %0d want 3", COUNT); else passed++;
    total++; if (EMPTY !== 1'b0) $display("FAIL alloc_empty got %0h want 0", EMPTY); else passed++;
  endtask

  task automatic test_inorder_retire();
    WB_VALID = 1'b1; WB_TAG = 4'd2; WB_DATA = 32'hAA; tick();
    total++; if (RETIRE_VALID !== 1'b0) $display("FAIL ooo_rv_t2 got %0h want 0", RETIRE_VALID); else passed++;
    WB_TAG = 4'd1; WB_DATA = 32'hBB; tick();
    total++; if (RETIRE_VALID !== 1'b0) $display("FAIL ooo_rv_t1 got %0h want 0", RETIRE_VALID); else passed++;
    WB_TAG = 4'd0; WB_DATA = 32'hCC; tick();
    WB_VALID = 1'b0;
    total++; if (RETIRE_VALID !== 1'b0) $display("FAIL ooo_no_bypass got %0h want 0", RETIRE_VALID); else passed++;
    tick();
    total++; if ({RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA} !== {1'b1, 4'd0, 5'd5, 32'hCC})
      $display("FAIL ret0 got v%0h t%0d a%0d d%0h want v1 t0 a5 dcc", RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA);
    else passed++;
    tick();
    total++; if ({RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA} !== {1'b1, 4'd1, 5'd6, 32'hBB})
      $display("FAIL ret1 got v%0h t%0d a%0d d%0h want v1 t1 a6 dbb", RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA);
    else passed++;
    tick();
    total++; if ({RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA} !== {1'b1, 4'd2, 5'd7, 32'hAA})
      $display("FAIL ret2 got v%0h t%0d a%0d d%0h want v1 t2 a7 daa", RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA);
    else passed++;
    tick();
    total++; if ({RETIRE_VALID, RETIRE_ARCH_REG, RETIRE_DATA} !== {1'b0, 5'd7, 32'hAA})
      $display("FAIL ret_hold got v%0h a%0d d%0h want v0 a7 daa", RETIRE_VALID, RETIRE_ARCH_REG, RETIRE_DATA);
    else passed++;
    total++; if ({COUNT, EMPTY} !== {5'd0, 1'b1}) $display("FAIL ret_drain got c%0d e%0h want c0 e1", COUNT, EMPTY); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'(i); tick();
    end
    total++; if (ALLOC_READY !== 1'b0) $display("FAIL full_ready got %0h want 0", ALLOC_READY); else passed++;
    total++; if (COUNT !== 5'd16) $display("FAIL full_count got %0d want 16", COUNT); else passed++;
    ALLOC_ARCH_REG = 5'd31; tick();
    total++; if ({COUNT, ALLOC_TAG} !== {5'd16, 4'd0}) $display("FAIL full_ignored got c%0d t%0d want c16 t0", COUNT, ALLOC_TAG); else passed++;
    ALLOC_VALID = 1'b0;
    WB_VALID = 1'b1; WB_TAG = 4'd0; WB_DATA = 32'h11; tick();
    WB_VALID = 1'b0;
    total++; if ({RETIRE_VALID, ALLOC_READY} !== 2'b00) $display("FAIL full_wb got rv%0h rdy%0h want 0 0", RETIRE_VALID, ALLOC_READY); else passed++;
    ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'd21; tick();
    total++; if ({RETIRE_VALID, RETIRE_TAG, RETIRE_DATA, RETIRE_ARCH_REG} !== {1'b1, 4'd0, 32'h11, 5'd0})
      $display("FAIL full_retire got v%0h t%0d d%0h a%0d want v1 t0 d11 a0", RETIRE_VALID, RETIRE_TAG, RETIRE_DATA, RETIRE_ARCH_REG);
    else passed++;
    total++; if ({COUNT, ALLOC_READY, ALLOC_TAG} !== {5'd15, 1'b1, 4'd0})
      $display("FAIL full_no_credit got c%0d rdy%0h t%0d want c15 rdy1 t0", COUNT, ALLOC_READY, ALLOC_TAG);
    else passed++;
    tick();
    ALLOC_VALID = 1'b0;
    total++; if ({COUNT, ALLOC_READY, ALLOC_TAG} !== {5'd16, 1'b0, 4'd1})
      $display("FAIL full_realloc got c%0d rdy%0h t%0d want c16 rdy0 t1", COUNT, ALLOC_READY, ALLOC_TAG);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'((i + 3) % 32); tick();
      ALLOC_VALID = 1'b0;
      WB_VALID = 1'b1; WB_TAG = 4'(i % 16); WB_DATA = 32'h1000 + 32'(i); tick();
      WB_VALID = 1'b0; tick();
      total++;
      if ({RETIRE_VALID, RETIRE_TAG, RETIRE_ARCH_REG, RETIRE_DATA} !== {1'b1, 4'(i % 16), 5'((i + 3) % 32), 32'h1000 + 32'(i)})
        $display("FAIL wrap%0d got v%0h t%0d a%0d d%0h want v1 t%0d a%0d d%0h", i, RETIRE_VALID, RETIRE_TAG,
                 RETIRE_ARCH_REG, RETIRE_DATA, i % 16, (i + 3) % 32, 32'h1000 + 32'(i));
      else passed++;
    end
    total++; if ({COUNT, EMPTY, ALLOC_TAG} !== {5'd0, 1'b1, 4'd4}) $display("FAIL wrap_end got c%0d e%0h t%0d want c0 e1 t4", COUNT, EMPTY, ALLOC_TAG); else passed++;
  endtask

  task automatic test_wb_err();
    do_reset();
    ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'd2; tick();
    ALLOC_ARCH_REG = 5'd3; tick();
    ALLOC_VALID = 1'b0;
    WB_VALID = 1'b1; WB_TAG = 4'd9; WB_DATA = 32'hDEAD; tick();
    total++; if ({WB_ERR, RETIRE_VALID} !== 2'b10) $display("FAIL err_unalloc got e%0h rv%0h want 1 0", WB_ERR, RETIRE_VALID); else passed++;
    WB_TAG = 4'd1; WB_DATA = 32'h77; tick();
    total++; if (WB_ERR !== 1'b0) $display("FAIL err_pulse_end got %0h want 0", WB_ERR); else passed++;
    WB_DATA = 32'h99; tick();
    total++; if (WB_ERR !== 1'b1) $display("FAIL err_double got %0h want 1", WB_ERR); else passed++;
    WB_TAG = 4'd0; WB_DATA = 32'hCC; tick();
    total++; if ({WB_ERR, RETIRE_VALID} !== 2'b00) $display("FAIL err_legal0 got e%0h rv%0h want 0 0", WB_ERR, RETIRE_VALID); else passed++;
    WB_DATA = 32'h88; tick();
    WB_VALID = 1'b0;
    total++; if ({WB_ERR, RETIRE_VALID, RETIRE_TAG, RETIRE_DATA} !== {1'b1, 1'b1, 4'd0, 32'hCC})
      $display("FAIL err_done0 got e%0h v%0h t%0d d%0h want e1 v1 t0 dcc", WB_ERR, RETIRE_VALID, RETIRE_TAG, RETIRE_DATA);
    else passed++;
    tick();
    total++; if ({WB_ERR, RETIRE_VALID, RETIRE_TAG, RETIRE_DATA} !== {1'b0, 1'b1, 4'd1, 32'h77})
      $display("FAIL err_keep1 got e%0h v%0h t%0d d%0h want e0 v1 t1 d77", WB_ERR, RETIRE_VALID, RETIRE_TAG, RETIRE_DATA);
    else passed++;
    tick();
    total++; if ({RETIRE_VALID, COUNT} !== {1'b0, 5'd0}) $display("FAIL err_no_extra got v%0h c%0d want v0 c0", RETIRE_VALID, COUNT); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'(10 + i); tick();
    end
    ALLOC_VALID = 1'b0;
    WB_VALID = 1'b1; WB_TAG = 4'd0; WB_DATA = 32'h5A; tick();
    total++; if (COUNT !== 5'd5) $display("FAIL flush_pre got %0d want 5", COUNT); else passed++;
    FLUSH = 1'b1; ALLOC_VALID = 1'b1; ALLOC_ARCH_REG = 5'd1; WB_TAG = 4'd9; WB_DATA = 32'h3; tick();
    FLUSH = 1'b0; ALLOC_VALID = 1'b0; WB_VALID = 1'b0;
    total++; if ({COUNT, EMPTY, ALLOC_TAG, RETIRE_VALID, WB_ERR} !== {5'd0, 1'b1, 4'd0, 1'b0, 1'b0})
      $display("FAIL flush got c%0d e%0h t%0d rv%0h err%0h want c0 e1 t0 rv0 err0", COUNT, EMPTY, ALLOC_TAG, RETIRE_VALID, WB_ERR);
    else passed++;
    tick();
    total++; if ({RETIRE_VALID, COUNT} !== {1'b0, 5'd0}) $display("FAIL flush_stale got v%0h c%0d want v0 c0", RETIRE_VALID, COUNT); else passed++;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_inorder_retire();
    test_full();
    test_wrap();
    test_wb_err();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
